clint_mh: RTL and testbench

- Parametrised multi-hart core-local interruptor.
- Provides a shared 64-bit mtime counter with a programmable prescaler, plus a per-hart 64-bit mtimecmp and a per-hart msip bit.
- Drives level-sensitive machine-timer (mtip) and machine-software (msip) interrupt lines into each hart's CSR/trap logic.
- Sits on the data bus beside RAM/peripherals. Single-cycle combinational reads, synchronous writes.

---
 rtl/clint_mh.sv | 121 ++++++++++++
 tb/tb_clint_mh.sv | 139 +++++++++++++
 2 files changed

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled 64-bit mtime, per-hart mtimecmp and msip.
// Reads are combinational, writes land at the next clk edge; mtip/msip outputs are registered.
module clint_mh #(
  parameter int          NUM_HARTS = 2,
  parameter int          TICK_DIV  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          data_i,
  output logic [31:0]          data_o,
  output logic [NUM_HARTS-1:0] mtip_o,
  output logic [NUM_HARTS-1:0] msip_o,
  output logic [63:0]          mtime_o
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] MSIP_END = 16'(4 * NUM_HARTS);
  localparam logic [15:0] CMP_BASE = 16'h4000;
  localparam logic [15:0] CMP_END  = 16'h4000 + 16'(8 * NUM_HARTS);
  localparam logic [15:0] MTIME_LO = 16'hBFF8;
  localparam logic [15:0] MTIME_HI = 16'hBFFC;

  logic [15:0]          div_cnt;
  logic                 tick;
  logic [63:0]          mtime_q;
  logic [63:0]          mtime_inc;
  logic [63:0]          mtime_next;
  logic [63:0]          mtimecmp_q    [NUM_HARTS];
  logic [63:0]          mtimecmp_next [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q;
  logic [NUM_HARTS-1:0] msip_next;

  logic [15:0] off;
  logic        hit;
  logic        wr;
  logic        sel_msip;
  logic        sel_cmp;
  logic        sel_mtlo;
  logic        sel_mthi;
  logic [3:0]  msip_idx;
  logic [3:0]  cmp_idx;

  assign off      = addr_i[15:0];
  assign hit      = ce_i && (addr_i[31:16] == BASE_ADDR[31:16]) && (addr_i[1:0] == 2'b00);
  assign wr       = hit && we_i;
  assign sel_msip = (off < MSIP_END);
  assign sel_cmp  = (off >= CMP_BASE) && (off < CMP_END);
  assign sel_mtlo = (off == MTIME_LO);
  assign sel_mthi = (off == MTIME_HI);
  assign msip_idx = off[5:2];
  assign cmp_idx  = off[6:3];

  assign tick      = (div_cnt == DIV_LAST);
  assign mtime_inc = mtime_q + 64'(tick);

  // A written half overrides the tick; the other half keeps the increment, carry included.
  assign mtime_next[31:0]  = (wr && sel_mtlo) ? data_i : mtime_inc[31:0];
  assign mtime_next[63:32] = (wr && sel_mthi) ? data_i : mtime_inc[63:32];

  always_comb begin
    msip_next = msip_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mtimecmp_next[h] = mtimecmp_q[h];
      if (wr && sel_msip && (msip_idx == 4'(h))) begin
        msip_next[h] = data_i[0];
      end
      if (wr && sel_cmp && (cmp_idx == 4'(h))) begin
        if (off[2]) begin
          mtimecmp_next[h][63:32] = data_i;
        end else begin
          mtimecmp_next[h][31:0] = data_i;
        end
      end
    end
  end

  always_comb begin
    data_o = 32'h0;
    if (hit) begin
      if (sel_mtlo) data_o = mtime_q[31:0];
      if (sel_mthi) data_o = mtime_q[63:32];
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (sel_msip && (msip_idx == 4'(h))) begin
          data_o = {31'b0, msip_q[h]};
        end
        if (sel_cmp && (cmp_idx == 4'(h))) begin
          data_o = off[2] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= 16'h0;
      mtime_q <= 64'h0;
      msip_q  <= '0;
      mtip_o  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
      end
    end else begin
      div_cnt <= tick ? 16'h0 : div_cnt + 16'h1;
      mtime_q <= mtime_next;
      msip_q  <= msip_next;
      // Compare on post-update values so a same-cycle mtimecmp write takes effect immediately.
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= mtimecmp_next[h];
        mtip_o[h]     <= (mtime_next >= mtimecmp_next[h]);
      end
    end
  end

  assign msip_o  = msip_q;
  assign mtime_o = mtime_q;

endmodule

// File: tb/tb_clint_mh.sv
// Directed bench for clint_mh: one instance at TICK_DIV=1 on the bus, one at TICK_DIV=4 for the prescaler.
module tb_clint_mh;

  localparam logic [31:0] B = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic [31:0] data_o;
  logic [1:0]  mtip_o;
  logic [1:0]  msip_o;
  logic [63:0] mtime_o;

  logic        ce4 = 1'b0;
  logic        we4 = 1'b0;
  logic [31:0] data4_o;
  logic [1:0]  mtip4_o;
  logic [1:0]  msip4_o;
  logic [63:0] mtime4_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdat;

  always #10 clk = ~clk;

  clint_mh #(.NUM_HARTS(2), .TICK_DIV(1), .BASE_ADDR(B)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .data_i(wdat),
    .data_o(data_o), .mtip_o(mtip_o), .msip_o(msip_o), .mtime_o(mtime_o)
  );

  clint_mh #(.NUM_HARTS(2), .TICK_DIV(4), .BASE_ADDR(B)) dut4 (
    .clk(clk), .rst(rst), .ce_i(ce4), .we_i(we4), .addr_i(addr), .data_i(wdat),
    .data_o(data4_o), .mtip_o(mtip4_o), .msip_o(msip4_o), .mtime_o(mtime4_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = a; wdat = d;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    d = data_o;
    ce = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mtime", mtime_o, 64'h0);
    chk("rst_mtip", 64'(mtip_o), 64'h0);
    chk("rst_msip", 64'(msip_o), 64'h0);

    repeat (10) @(posedge clk); #1;
    rd(B + 32'hBFF8, rdat); chk("mtime_10", 64'(rdat), 64'd10);
    chk("ce0_data4", 64'(data4_o), 64'h0);
    rd(B + 32'h4000, rdat); chk("cmp0_lo_rst", 64'(rdat), 64'hFFFF_FFFF);
    rd(B + 32'h4004, rdat); chk("cmp0_hi_rst", 64'(rdat), 64'hFFFF_FFFF);

    repeat (30) @(posedge clk); #1;
    chk("div4_mtime_40cyc", mtime4_o, 64'd10);

    // mtime=5, then cmp1 = {0, 20}
    wr(B + 32'hBFF8, 32'd5);
    wr(B + 32'h400C, 32'd0);
    wr(B + 32'h4008, 32'd20);
    repeat (12) @(posedge clk); #1;
    chk("mtime_19", mtime_o, 64'd19);
    chk("mtip_before", 64'(mtip_o), 64'h0);
    @(posedge clk); #1;
    chk("mtime_20", mtime_o, 64'd20);
    chk("mtip_rise", 64'(mtip_o), 64'h2);
    wr(B + 32'h4008, 32'hFFFF_FFFF);
    chk("mtip_fall", 64'(mtip_o), 64'h0);

    wr(B + 32'hBFF8, 32'hFFFF_FFFE);
    wr(B + 32'hBFFC, 32'h0);
    @(posedge clk); #1;
    rd(B + 32'hBFFC, rdat); chk("carry_hi", 64'(rdat), 64'h1);
    rd(B + 32'hBFF8, rdat); chk("carry_lo", 64'(rdat), 64'h0);
    chk("carry_mtime", mtime_o, 64'h1_0000_0000);
    wr(B + 32'hBFF8, 32'hFFFF_FFFF);
    wr(B + 32'hBFFC, 32'h55);
    chk("hi_wr_on_carry", mtime_o, 64'h0000_0055_0000_0000);
    chk("mtip_big_mtime", 64'(mtip_o), 64'h2);

    wr(B + 32'h4, 32'hFFFF_FFFF);
    chk("msip_set", 64'(msip_o), 64'h2);
    rd(B + 32'h4, rdat); chk("msip1_rd", 64'(rdat), 64'h1);
    rd(B + 32'h0, rdat); chk("msip0_rd", 64'(rdat), 64'h0);
    wr(B + 32'h4, 32'h0);
    chk("msip_clr", 64'(msip_o), 64'h0);

    wr(B + 32'h8, 32'h1);
    chk("msip_h2_ign", 64'(msip_o), 64'h0);
    rd(B + 32'h8, rdat); chk("msip_h2_rd", 64'(rdat), 64'h0);
    wr(B + 32'h4002, 32'h0);
    rd(B + 32'h4000, rdat); chk("unaligned_ign", 64'(rdat), 64'hFFFF_FFFF);
    rd(B + 32'h4002, rdat); chk("unaligned_rd", 64'(rdat), 64'h0);
    wr(B + 32'h4010, 32'h0);
    rd(B + 32'h4010, rdat); chk("cmp_h2_rd", 64'(rdat), 64'h0);
    chk("cmp_h2_mtip", 64'(mtip_o), 64'h2);
    wr(32'h0203_0004, 32'h1);
    chk("outside_ign", 64'(msip_o), 64'h0);
    rd(32'h0203_0004, rdat); chk("outside_rd", 64'(rdat), 64'h0);

    ce = 1'b0; addr = B + 32'hBFF8; #1;
    chk("ce0_data", 64'(data_o), 64'h0);

    // reset wins over a simultaneous write
    rst = 1'b1; ce = 1'b1; we = 1'b1; addr = B + 32'h4; wdat = 32'h1;
    @(posedge clk); #1;
    chk("midrst_mtime", mtime_o, 64'h0);
    chk("midrst_mtime4", mtime4_o, 64'h0);
    chk("midrst_msip", 64'(msip_o), 64'h0);
    chk("midrst_mtip", 64'(mtip_o), 64'h0);
    rst = 1'b0; ce = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_count", mtime_o, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
